tt_um_jimktrains_vslc_eeprom_responder: RTL and testbench



---
 rtl/tt_um_jimktrains_vslc_eeprom_responder_pkg.sv | 15 +
 rtl/tt_um_jimktrains_vslc_spi_sync.sv | 27 ++
 rtl/tt_um_jimktrains_vslc_eeprom_responder.sv | 145 ++++++++++++++
 tb/tb_tt_um_jimktrains_vslc_eeprom_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_jimktrains_vslc_eeprom_responder_pkg.sv
// Shared constants and FSM encoding for the VSLC SPI EEPROM responder.
package tt_um_jimktrains_vslc_eeprom_responder_pkg;

   localparam int         ADDR_W_DEF = 10;
   localparam logic [7:0] OP_READ    = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } state_e;

endpackage

// File: rtl/tt_um_jimktrains_vslc_spi_sync.sv
// N-flop synchronizer for one SPI pin, plus rise/fall detect on the synchronized level.
module tt_um_jimktrains_vslc_spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES:0] chain;
   logic            prev_q;

   assign chain[0] = pin_i;

   // Left unreset so a reset with cs already low cannot fabricate a cs edge.
   always_ff @(posedge clk) begin
      chain[STAGES:1] <= chain[STAGES-1:0];
      prev_q          <= chain[STAGES];
   end

   assign lvl_o  = chain[STAGES];
   assign rise_o = chain[STAGES] & ~prev_q;
   assign fall_o = ~chain[STAGES] & prev_q;

endmodule

// File: rtl/tt_um_jimktrains_vslc_eeprom_responder.sv
// 25-series READ (0x03) responder on a half-duplex SPI line, oversampled on clk.
module tt_um_jimktrains_vslc_eeprom_responder
   import tt_um_jimktrains_vslc_eeprom_responder_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_cs_n,
   input  logic              spi_hold_n,
   input  logic              sd_in,
   output logic              sd_out,
   output logic              sd_oe,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic              busy,
   output logic              cmd_err
);

   // Pin order in the synchronizer array: 0 sck, 1 cs_n, 2 hold_n, 3 sd.
   logic [3:0] pins, lvl, rise, fall;
   logic       unused_sync;

   assign pins        = {sd_in, spi_hold_n, spi_cs_n, spi_clk};
   assign unused_sync = ^{lvl[0], rise[3:2], fall[3:2]};

   tt_um_jimktrains_vslc_spi_sync #(.STAGES(SYNC_STAGES)) u_sync [3:0] (
      .clk    (clk),
      .pin_i  (pins),
      .lvl_o  (lvl),
      .rise_o (rise),
      .fall_o (fall)
   );

   logic sck_rise, sck_fall, cs_rise, cs_fall, cs_n_s, sd_s;

   assign sck_rise = rise[0] & lvl[2];
   assign sck_fall = fall[0] & lvl[2];
   assign cs_rise  = rise[1];
   assign cs_fall  = fall[1];
   assign cs_n_s   = lvl[1];
   assign sd_s     = lvl[3];

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              sd_out_q, sd_out_d;
   logic              err_q, err_d;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   logic [7:0]        mem_q [2**ADDR_W];
   logic [7:0]        rdata_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      addr_d   = addr_q;
      sd_out_d = sd_out_q;
      err_d    = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = addr_q;
      // A cs rise outranks any SCK edge seen in the same cycle.
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (cs_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
            end
            ST_CMD: if (sck_rise) begin
               op_d  = {op_q[6:0], sd_s};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d = '0;
                  if (op_d == OP_READ) begin
                     state_d = ST_ADDR;
                  end else begin
                     state_d = ST_IGNORE;
                     err_d   = 1'b1;
                  end
               end
            end
            ST_ADDR: if (sck_rise) begin
               // Shifting through an ADDR_W register drops the upper address bits.
               addr_d = {addr_q[ADDR_W-2:0], sd_s};
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  cnt_d   = '0;
                  state_d = ST_DATA;
                  rd_en   = 1'b1;
                  rd_addr = addr_d;
               end
            end
            ST_DATA: if (sck_fall) begin
               sd_out_d = rdata_q[3'd7 - cnt_q[2:0]];
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d   = '0;
                  addr_d  = addr_q + ADDR_W'(1);
                  rd_en   = 1'b1;
                  rd_addr = addr_d;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         addr_q   <= '0;
         sd_out_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         sd_out_q <= sd_out_d;
         err_q    <= err_d;
      end
   end

   // rdata_q only moves on a prefetch, so later loads cannot disturb the byte in flight.
   always_ff @(posedge clk) begin
      if (load_en) mem_q[load_addr] <= load_data;
      if (rd_en)   rdata_q          <= mem_q[rd_addr];
   end

   assign sd_out  = sd_out_q;
   assign sd_oe   = (state_q == ST_DATA) && !cs_n_s;
   assign busy    = (state_q != ST_IDLE);
   assign cmd_err = err_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_eeprom_responder.sv
// Directed bench: drives SPI mode-0 READ transactions and checks returned bytes and status.
module tb_tt_um_jimktrains_vslc_eeprom_responder;

   localparam int ADDR_W = 10;
   localparam int H      = 6;   // SCK half period in clk cycles

   logic              clk, rst;
   logic              spi_clk, spi_cs_n, spi_hold_n, sd_in;
   logic              sd_out, sd_oe, busy, cmd_err;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        load_data;

   int errors = 0;
   int checks = 0;
   int oe_hi  = 0;
   int err_pulses = 0;

   tt_um_jimktrains_vslc_eeprom_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_clk    (spi_clk),
      .spi_cs_n   (spi_cs_n),
      .spi_hold_n (spi_hold_n),
      .sd_in      (sd_in),
      .sd_out     (sd_out),
      .sd_oe      (sd_oe),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .busy       (busy),
      .cmd_err    (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic spi_cycle(input logic mosi, output logic miso);
      sd_in = mosi;
      repeat (H) @(negedge clk);
      miso = sd_out;
      if (sd_oe === 1'b1) oe_hi++;
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic dummy;
      for (int i = 7; i >= 0; i--) spi_cycle(b[i], dummy);
   endtask

   task automatic read_bits(input int n, inout logic [7:0] b);
      logic bit_v;
      for (int i = 0; i < n; i++) begin
         spi_cycle(1'b0, bit_v);
         b = {b[6:0], bit_v};
      end
   endtask

   task automatic send_read(input logic [15:0] a);
      send_byte(8'h03);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic start_txn();
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic end_txn();
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      logic       m;
      rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_hold_n = 1'b1; sd_in = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sd_out", sd_out, 1'b0);
      chk("rst_sd_oe", sd_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_err", cmd_err, 1'b0);

      // Four-byte read from 0x0000
      load(10'h000, 8'h00); load(10'h001, 8'h10); load(10'h002, 8'h00); load(10'h003, 8'h20);
      oe_hi = 0;
      start_txn();
      chk("busy_after_cs", busy, 1'b1);
      send_read(16'h0000);
      b = '0; read_bits(8, b); chk("rd0_byte0", b, 8'h00);
      b = '0; read_bits(8, b); chk("rd0_byte1", b, 8'h10);
      b = '0; read_bits(8, b); chk("rd0_byte2", b, 8'h00);
      b = '0; read_bits(8, b); chk("rd0_byte3", b, 8'h20);
      chk("rd0_oe_count", oe_hi, 32);
      end_txn();
      chk("rd0_busy_end", busy, 1'b0);
      chk("rd0_oe_end", sd_oe, 1'b0);
      chk("rd0_no_err", err_pulses, 0);

      // Wrap from top of memory
      load(10'h3FF, 8'hA5); load(10'h000, 8'h3C);
      start_txn();
      send_read(16'h03FF);
      b = '0; read_bits(8, b); chk("wrap_byte0", b, 8'hA5);
      b = '0; read_bits(8, b); chk("wrap_byte1", b, 8'h3C);
      end_txn();

      // Unsupported opcode
      err_pulses = 0; oe_hi = 0;
      start_txn();
      send_byte(8'h05);
      send_byte(8'hFF);
      send_byte(8'hFF);
      end_txn();
      chk("bad_op_err_pulse", err_pulses, 1);
      chk("bad_op_oe", oe_hi, 0);
      start_txn();
      send_read(16'h03FF);
      b = '0; read_bits(8, b); chk("bad_op_then_read", b, 8'hA5);
      end_txn();

      // Hold mid-byte: bit 6 driven, then 5 held SCK periods
      load(10'h010, 8'hC3);
      start_txn();
      send_read(16'h0010);
      b = '0; read_bits(1, b);
      repeat (3) @(negedge clk);
      spi_hold_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         spi_cycle(1'b0, m);
         chk("hold_frozen", m, 1'b1);
      end
      repeat (3) @(negedge clk);
      spi_hold_n = 1'b1;
      read_bits(7, b);
      chk("hold_byte", b, 8'hC3);
      end_txn();

      // Abort after 12 address bits, then fresh read
      load(10'h002, 8'h5A);
      start_txn();
      send_byte(8'h03);
      for (int i = 0; i < 12; i++) spi_cycle(1'b1, m);
      end_txn();
      chk("abort_busy", busy, 1'b0);
      start_txn();
      send_read(16'h0002);
      b = '0; read_bits(8, b); chk("abort_then_read", b, 8'h5A);
      end_txn();

      // Reset during DATA, SCK keeps toggling with cs low
      start_txn();
      send_read(16'h0001);
      b = '0; read_bits(4, b);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_oe", sd_oe, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_sd_out", sd_out, 1'b0);
      oe_hi = 0;
      for (int i = 0; i < 8; i++) spi_cycle(1'b1, m);
      chk("rst_idle_oe", oe_hi, 0);
      chk("rst_idle_busy", busy, 1'b0);
      end_txn();
      start_txn();
      send_read(16'hFC01);
      b = '0; read_bits(8, b); chk("rst_then_read_hi_addr", b, 8'h10);
      end_txn();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
